// File: rtl/cnt_reg_ext.sv
// Parametrised load/count/shift register with step, limit, wrap or saturate,
// terminal-count pulse and sticky overflow flag.
module cnt_reg_ext #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic              shl,
    input  logic              shr,
    input  logic              sin,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lim,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              zero
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;

    assign w_step = WIDTH'(step);
    // One extra bit so a sum past the top of the register still compares above lim.
    assign w_sum  = {1'b0, r_out} + {1'b0, w_step};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_out_nxt = r_out;
        w_tc_nxt  = 1'b0;
        w_ovf_nxt = r_ovf;
        if (clr) begin
            w_out_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (ld) begin
            w_out_nxt = in;
            w_ovf_nxt = 1'b0;
        end else if (shl) begin
            w_out_nxt = {r_out[WIDTH-2:0], sin};
        end else if (shr) begin
            w_out_nxt = {sin, r_out[WIDTH-1:1]};
        end else if (inc && !dec) begin
            if (w_sum > {1'b0, lim}) begin
                w_out_nxt = SAT ? lim : '0;
                w_tc_nxt  = 1'b1;
                w_ovf_nxt = 1'b1;
            end else begin
                w_out_nxt = w_sum[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (r_out < w_step) begin
                w_out_nxt = SAT ? '0 : lim;
                w_tc_nxt  = 1'b1;
                w_ovf_nxt = 1'b1;
            end else begin
                w_out_nxt = r_out - w_step;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_tc  <= w_tc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign ovf  = r_ovf;
    assign zero = (r_out == '0);

endmodule

// File: tb/tb_cnt_reg_ext.sv
// Directed bench for cnt_reg_ext: a wrap instance and a saturate instance share
// the same stimulus; expected values are hand-computed.
module tb_cnt_reg_ext;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, ld, shl, shr, sin, inc, dec;
    logic [3:0] step;
    logic [7:0] lim, din;
    logic [7:0] out_w, out_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, zero_w, zero_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cnt_reg_ext #(.WIDTH(8), .STEP_W(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .shl(shl), .shr(shr), .sin(sin),
        .inc(inc), .dec(dec), .step(step), .lim(lim), .in(din),
        .out(out_w), .tc(tc_w), .ovf(ovf_w), .zero(zero_w)
    );

    cnt_reg_ext #(.WIDTH(8), .STEP_W(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .shl(shl), .shr(shr), .sin(sin),
        .inc(inc), .dec(dec), .step(step), .lim(lim), .in(din),
        .out(out_s), .tc(tc_s), .ovf(ovf_s), .zero(zero_s)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        clr = 1'b0; ld = 1'b0; shl = 1'b0; shr = 1'b0;
        sin = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with random inputs
        rst  = 1'b0;
        clr  = 1'($urandom); ld  = 1'($urandom); shl = 1'($urandom); shr = 1'($urandom);
        sin  = 1'($urandom); inc = 1'($urandom); dec = 1'($urandom);
        step = 4'($urandom); lim = 8'($urandom); din = 8'($urandom);
        tick(); tick();
        check("rst_out_w",  out_w,  0);
        check("rst_tc_w",   tc_w,   0);
        check("rst_ovf_w",  ovf_w,  0);
        check("rst_zero_w", zero_w, 1);
        check("rst_out_s",  out_s,  0);
        check("rst_zero_s", zero_s, 1);
        idle();
        step = 4'd3; lim = 8'd10; din = 8'd9;
        rst = 1'b1;
        tick();
        check("hold_out", out_w, 0);
        check("hold_tc",  tc_w,  0);

        // 2: wrap up (and saturate on the same stimulus)
        ld = 1'b1; tick(); ld = 1'b0;
        check("ld9_out", out_w, 9);
        check("ld9_zero", zero_w, 0);
        inc = 1'b1; tick();
        check("wrap_out", out_w, 0);
        check("wrap_tc",  tc_w,  1);
        check("wrap_ovf", ovf_w, 1);
        check("wrap_zero", zero_w, 1);
        check("satup_out", out_s, 10);
        check("satup_tc",  tc_s,  1);
        tick();
        check("wrap2_out", out_w, 3);
        check("wrap2_tc",  tc_w,  0);
        check("wrap2_ovf", ovf_w, 1);
        check("satup2_out", out_s, 10);
        check("satup2_tc",  tc_s,  1);
        inc = 1'b0; tick();
        check("idle_tc_w", tc_w, 0);
        check("idle_out_w", out_w, 3);

        // 3: saturate down (wrap instance wraps to lim)
        lim = 8'd200; step = 4'd4; din = 8'd5;
        ld = 1'b1; tick(); ld = 1'b0;
        check("ld5_ovf", ovf_s, 0);
        dec = 1'b1; tick();
        check("dn1_out_s", out_s, 1);
        check("dn1_tc_s",  tc_s,  0);
        tick();
        check("dn2_out_s", out_s, 0);
        check("dn2_tc_s",  tc_s,  1);
        check("dn2_ovf_s", ovf_s, 1);
        check("dn2_zero_s", zero_s, 1);
        check("dn2_out_w", out_w, 200);
        check("dn2_tc_w",  tc_w,  1);
        tick();
        check("dn3_out_s", out_s, 0);
        check("dn3_tc_s",  tc_s,  1);
        check("dn3_out_w", out_w, 196);
        check("dn3_tc_w",  tc_w,  0);
        check("dn3_ovf_w", ovf_w, 1);
        dec = 1'b0;

        // 4: priority
        din = 8'h55; clr = 1'b1; ld = 1'b1; inc = 1'b1; tick(); idle();
        check("clr_out", out_w, 0);
        check("clr_ovf", ovf_w, 0);
        check("clr_tc",  tc_w,  0);
        din = 8'h81; ld = 1'b1; shl = 1'b1; tick(); idle();
        check("ldshl_out", out_w, 8'h81);
        shl = 1'b1; sin = 1'b1; tick(); idle();
        check("shl_out", out_w, 8'h03);
        inc = 1'b1; dec = 1'b1; tick(); idle();
        check("incdec_out", out_w, 8'h03);
        check("incdec_tc",  tc_w,  0);

        // Boundaries: sum equal to lim, step of zero, start above lim
        lim = 8'd10; step = 4'd3; din = 8'd7;
        ld = 1'b1; tick(); ld = 1'b0;
        inc = 1'b1; tick(); inc = 1'b0;
        check("eqlim_out", out_w, 10);
        check("eqlim_tc",  tc_w,  0);
        step = 4'd0; inc = 1'b1; tick(); inc = 1'b0;
        check("step0_out", out_w, 10);
        check("step0_tc",  tc_w,  0);
        din = 8'd50; step = 4'd1;
        ld = 1'b1; tick(); ld = 1'b0;
        inc = 1'b1; tick(); inc = 1'b0;
        check("above_out_w", out_w, 0);
        check("above_tc_w",  tc_w,  1);
        check("above_out_s", out_s, 10);

        // 5: shift right with ovf held at 1
        lim = 8'hFF; din = 8'hFF;
        ld = 1'b1; tick(); ld = 1'b0;
        inc = 1'b1; tick(); inc = 1'b0;
        check("top_out", out_w, 0);
        check("top_ovf", ovf_w, 1);
        shr = 1'b1; sin = 1'b1; tick();
        check("shr0_out", out_w, 8'h80);
        check("shr0_tc",  tc_w,  0);
        tick();
        check("shr1_out", out_w, 8'hC0);
        sin = 1'b0; tick(); idle();
        check("shr2_out", out_w, 8'h60);
        check("shr2_ovf", ovf_w, 1);

        // 6: async reset mid-count
        din = 8'd0; step = 4'd1;
        ld = 1'b1; tick(); ld = 1'b0;
        inc = 1'b1; tick(); tick(); tick();
        check("cnt3_out", out_w, 3);
        #3 rst = 1'b0;
        #1;
        check("arst_out",  out_w, 0);
        check("arst_ovf",  ovf_w, 0);
        check("arst_zero", zero_w, 1);
        tick();
        check("arst_hold", out_w, 0);
        rst = 1'b1;
        tick();
        check("resume1", out_w, 1);
        tick();
        check("resume2", out_w, 2);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
